fetch_queue: RTL and testbench

- First-word-fall-through instruction buffer between the fetch stage and the decode stage.
- Upstream: the PC register and instruction memory. Downstream: the IF/ID side of decode and the hazard unit.
- Decouples fetch from decode stalls: fetch keeps filling while decode is stalled.
- Discards all buffered instructions on a redirect (branch/jump taken).
- Its `in_ready` output drives the PC write-enable, so the PC advances only when an instruction is accepted.

---
 rtl/fetch_queue.sv | 72 +++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through instruction buffer between fetch and decode.
// in_ready doubles as the PC write-enable; a flush from EX discards every entry.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_q;
  logic             push;
  logic             pop;

  // in_ready deliberately ignores out_ready: no comb path between the two handshakes
  assign in_ready  = (count_q != FULL_CNT) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  // empty queue presents PC 0 / instr 0 so decode sees a NOP
  assign out_pc       = out_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign out_instr    = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign out_pc_plus4 = out_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage carries no reset; out_valid gates its contents
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table, hand-written corner sequences and random
// traffic, all checked against a queue-based reference model of the buffer.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_pc = 32'h0;
  logic [31:0]      in_instr = 32'h0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc_plus4;
  logic [31:0]      out_instr;
  logic [PTR_W:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fl;
    logic        ordy;
    int          e_count;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;
  vec_t vecs[11];

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model given the inputs currently applied.
  task automatic check_model(input string tag);
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    e_pc    = (mq.size() != 0) ? mq[0].pc    : 32'h0;
    e_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
    chk({tag, ":count"},     32'(count),     32'(mq.size()));
    chk({tag, ":in_ready"},  32'(in_ready),  32'((mq.size() != DEPTH) && !flush));
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ":out_pc"},    out_pc,         e_pc);
    chk({tag, ":out_instr"}, out_instr,      e_instr);
    chk({tag, ":pc_plus4"},  out_pc_plus4,   e_pc + 32'd4);
  endtask

  task automatic apply(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    flush     = fl;
    out_ready = ordy;
    #1;
  endtask

  // Clock edge plus model update from the applied inputs.
  task automatic advance();
    bit do_pop;
    bit do_push;
    do_pop  = (mq.size() != 0) && out_ready;
    do_push = in_valid && (mq.size() != DEPTH);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: in_pc, instr: in_instr});
    end
    #1;
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic fl, input logic ordy, input string tag);
    apply(iv, pc, instr, fl, ordy);
    check_model(tag);
    advance();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h2ff4, 32'hA0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0,    32'h0};
    vecs[1]  = '{1'b1, 32'h2ff8, 32'hA1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h2ff4, 32'hA0};
    vecs[2]  = '{1'b1, 32'h2ffc, 32'hA2, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h2ff4, 32'hA0};
    vecs[3]  = '{1'b1, 32'h3000, 32'hA3, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h2ff4, 32'hA0};
    vecs[4]  = '{1'b0, 32'h0,    32'h0,  1'b0, 1'b0, 4, 1'b0, 1'b1, 32'h2ff4, 32'hA0};
    vecs[5]  = '{1'b0, 32'h0,    32'h0,  1'b0, 1'b1, 4, 1'b0, 1'b1, 32'h2ff4, 32'hA0};
    vecs[6]  = '{1'b0, 32'h0,    32'h0,  1'b0, 1'b1, 3, 1'b1, 1'b1, 32'h2ff8, 32'hA1};
    vecs[7]  = '{1'b0, 32'h0,    32'h0,  1'b0, 1'b1, 2, 1'b1, 1'b1, 32'h2ffc, 32'hA2};
    vecs[8]  = '{1'b0, 32'h0,    32'h0,  1'b0, 1'b1, 1, 1'b1, 1'b1, 32'h3000, 32'hA3};
    vecs[9]  = '{1'b0, 32'h0,    32'h0,  1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0,    32'h0};
    vecs[10] = '{1'b0, 32'h0,    32'h0,  1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0,    32'h0};

    // reset state
    #1;
    chk("rst:count",     32'(count),     32'h0);
    chk("rst:out_valid", 32'(out_valid), 32'h0);
    chk("rst:out_instr", out_instr,      32'h0);
    chk("rst:pc_plus4",  out_pc_plus4,   32'h4);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fill then drain
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].fl, vecs[i].ordy);
      chk($sformatf("vec%0d:count", i),     32'(count),     32'(vecs[i].e_count));
      chk($sformatf("vec%0d:in_ready", i),  32'(in_ready),  32'(vecs[i].e_in_ready));
      chk($sformatf("vec%0d:out_valid", i), 32'(out_valid), 32'(vecs[i].e_out_valid));
      chk($sformatf("vec%0d:out_pc", i),    out_pc,         vecs[i].e_pc);
      chk($sformatf("vec%0d:out_instr", i), out_instr,      vecs[i].e_instr);
      chk($sformatf("vec%0d:pc_plus4", i),  out_pc_plus4,   vecs[i].e_pc + 32'd4);
      check_model($sformatf("vec%0d", i));
      advance();
    end

    // simultaneous push/pop at count 2, pointers wrap twice
    step(1'b1, 32'h100, 32'hC100, 1'b0, 1'b0, "sim_pre0");
    step(1'b1, 32'h104, 32'hC104, 1'b0, 1'b0, "sim_pre1");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h108 + 32'(4 * i), 32'hC108 + 32'(4 * i), 1'b0, 1'b1, "sim");
      chk("sim:count_two", 32'(count), 32'd2);
    end

    // full plus pop
    step(1'b1, 32'h200, 32'hD0, 1'b0, 1'b0, "fill3");
    step(1'b1, 32'h204, 32'hD1, 1'b0, 1'b0, "fill4");
    apply(1'b1, 32'h208, 32'hD2, 1'b0, 1'b1);
    chk("full_pop:in_ready", 32'(in_ready), 32'h0);
    check_model("full_pop");
    advance();
    chk("full_pop:count", 32'(count), 32'd3);
    step(1'b1, 32'h20c, 32'hD3, 1'b0, 1'b0, "full_pop_next");
    chk("full_pop:accepted", 32'(count), 32'd4);

    // flush with push and pop requested
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "pre_flush");
    apply(1'b1, 32'hdead, 32'hBAD, 1'b1, 1'b1);
    check_model("flush");
    advance();
    chk("flush:count",     32'(count),     32'h0);
    chk("flush:out_valid", 32'(out_valid), 32'h0);
    step(1'b1, 32'h4000, 32'h13, 1'b0, 1'b0, "post_flush");
    chk("post_flush:out_pc",    out_pc,         32'h4000);
    chk("post_flush:out_valid", 32'(out_valid), 32'h1);

    // back-to-back flush
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h5000, 32'h55, 1'b1, 1'b1, "b2b_flush");
      chk("b2b_flush:count", 32'(count), 32'h0);
    end

    // PC+4 wrap
    step(1'b1, 32'hFFFF_FFFC, 32'h77, 1'b0, 1'b0, "wrap_push");
    chk("plus4_wrap", out_pc_plus4, 32'h0);
    step(1'b1, 32'h0, 32'h78, 1'b0, 1'b0, "fill_b");
    step(1'b1, 32'h4, 32'h79, 1'b0, 1'b0, "fill_c");

    // async reset mid-stream with count 3
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_arst:count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("arst:out_valid", 32'(out_valid), 32'h0);
    chk("arst:count",     32'(count),     32'h0);
    chk("arst:out_instr", out_instr,      32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h2ff4, 32'hA0, 1'b0, 1'b0, "arst_push");
    chk("arst_push:out_pc",    out_pc,         32'h2ff4);
    chk("arst_push:out_valid", 32'(out_valid), 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, $urandom,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
